// File: rtl/alu_result_tx_framer.sv
// rtl/alu_result_tx_framer.sv - frames 2*D_WIDTH-bit ALU results into two UART TX bytes, low byte first
module alu_result_tx_framer #(
  parameter int D_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2*D_WIDTH-1:0]   ALU_OUT,
  input  logic                   OUT_VALID,
  input  logic                   TX_BUSY,
  output logic [D_WIDTH-1:0]     TX_P_DATA,
  output logic                   TX_D_VLD,
  output logic                   HOLD_FULL,
  output logic                   OVERRUN
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    WAIT_LO,
    SEND_HI,
    WAIT_HI
  } state_t;

  state_t               state;
  logic [2*D_WIDTH-1:0] act_r;
  logic [2*D_WIDTH-1:0] hold_r;
  logic                 hold_take;

  // HOLD is drained into ACT on this edge, so it can accept a new result at the same time.
  assign hold_take = (state == WAIT_HI) && !TX_BUSY && HOLD_FULL;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      act_r     <= '0;
      hold_r    <= '0;
      HOLD_FULL <= 1'b0;
      OVERRUN   <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (OUT_VALID) begin
            act_r     <= ALU_OUT;
            TX_P_DATA <= ALU_OUT[D_WIDTH-1:0];
            TX_D_VLD  <= 1'b1;
            state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= act_r[2*D_WIDTH-1:D_WIDTH];
            TX_D_VLD  <= 1'b1;
            state     <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (!TX_BUSY) begin
            if (HOLD_FULL) begin
              act_r     <= hold_r;
              TX_P_DATA <= hold_r[D_WIDTH-1:0];
              TX_D_VLD  <= 1'b1;
              state     <= SEND_LO;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          TX_D_VLD <= 1'b0;
          state    <= IDLE;
        end
      endcase

      if (state != IDLE && OUT_VALID) begin
        if (!HOLD_FULL || hold_take) begin
          hold_r    <= ALU_OUT;
          HOLD_FULL <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (hold_take) begin
        HOLD_FULL <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_tx_framer.sv
// tb/tb_alu_result_tx_framer.sv - scoreboard bench for alu_result_tx_framer with a busy/valid UART TX model
module tb_alu_result_tx_framer;

  logic        CLK;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        TX_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        HOLD_FULL;
  logic        OVERRUN;

  alu_result_tx_framer #(.D_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .HOLD_FULL (HOLD_FULL),
    .OVERRUN   (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          nbytes = 0;
  int          bcnt = 0;
  int          dly = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          last_gap = 0;
  logic        inj_arm = 1'b0;
  logic        ov_clr = 1'b0;
  int          inj_at = 0;
  logic [15:0] inj_data = '0;
  int          base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // UART TX model: accepts a byte when valid is seen, raises busy two cycles later for ten cycles.
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ov_clr) begin
        OUT_VALID = 1'b0;
        ov_clr    = 1'b0;
      end
      if (bcnt > 0) begin
        check("vld_in_busy", {31'd0, TX_D_VLD}, 32'd0);
        bcnt--;
        if (bcnt == 0) begin
          TX_BUSY  = 1'b0;
          fall_cyc = cyc;
          if (inj_arm && nbytes == inj_at) begin
            ALU_OUT   = inj_data;
            OUT_VALID = 1'b1;
            ov_clr    = 1'b1;
            inj_arm   = 1'b0;
          end
        end
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          TX_BUSY = 1'b1;
          bcnt    = 10;
        end
      end else if (TX_D_VLD) begin
        nbytes++;
        last_gap = cyc - fall_cyc;
        if (exp_q.size() == 0) check("extra_byte", {24'd0, TX_P_DATA}, 32'h100);
        else check("byte", {24'd0, TX_P_DATA}, {24'd0, exp_q.pop_front()});
        dly = 2;
      end
    end
  end

  task automatic pulse(input logic [15:0] d, input bit chk_lat);
    ALU_OUT   = d;
    OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    if (chk_lat) begin
      check("latency_vld", {31'd0, TX_D_VLD}, 32'd1);
      check("latency_data", {24'd0, TX_P_DATA}, {24'd0, d[7:0]});
    end
  endtask

  task automatic wait_bytes(input int n);
    int k;
    for (k = 0; k < 400 && nbytes < n; k++) @(negedge CLK);
    if (nbytes < n) check("wait_bytes_timeout", nbytes, n);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 1000 && !(exp_q.size() == 0 && bcnt == 0 && dly == 0); k++) @(negedge CLK);
    if (k >= 1000) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    RST       = 1'b0;
    ALU_OUT   = '0;
    OUT_VALID = 1'b0;

    // reset held with OUT_VALID toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ALU_OUT   = 16'($urandom);
      OUT_VALID = ~OUT_VALID;
    end
    @(negedge CLK);
    OUT_VALID = 1'b0;
    check("rst_data", {24'd0, TX_P_DATA}, 32'd0);
    check("rst_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("rst_hold", {31'd0, HOLD_FULL}, 32'd0);
    check("rst_ovr", {31'd0, OVERRUN}, 32'd0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("post_rst_data", {24'd0, TX_P_DATA}, 32'd0);

    // single result
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    pulse(16'hA55A, 1);
    check("single_hold", {31'd0, HOLD_FULL}, 32'd0);
    drain();
    check("single_idle_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("single_hold_end", {31'd0, HOLD_FULL}, 32'd0);
    check("single_last_data", {24'd0, TX_P_DATA}, 32'hA5);

    // back-to-back
    base = nbytes;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h03);
    pulse(16'h0102, 1);
    repeat (2) @(negedge CLK);
    pulse(16'h0304, 0);
    check("b2b_hold_set", {31'd0, HOLD_FULL}, 32'd1);
    wait_bytes(base + 3);
    check("b2b_hold_clr", {31'd0, HOLD_FULL}, 32'd0);
    check("b2b_gap", last_gap, 1);
    drain();
    check("b2b_ovr", {31'd0, OVERRUN}, 32'd0);

    // simultaneous hold drain and new result on the WAIT_HI exit edge
    base     = nbytes;
    inj_at   = nbytes + 2;
    inj_data = 16'h00FF;
    inj_arm  = 1'b1;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    pulse(16'h1234, 1);
    @(negedge CLK);
    pulse(16'hBEEF, 0);
    check("sim_hold_set", {31'd0, HOLD_FULL}, 32'd1);
    wait_bytes(base + 3);
    check("sim_hold_refill", {31'd0, HOLD_FULL}, 32'd1);
    drain();
    check("sim_ovr", {31'd0, OVERRUN}, 32'd0);
    check("sim_hold_end", {31'd0, HOLD_FULL}, 32'd0);
    check("sim_count", nbytes, base + 6);

    // overrun
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h22);
    pulse(16'h1111, 1);
    pulse(16'h2222, 0);
    pulse(16'h3333, 0);
    check("ovr_set", {31'd0, OVERRUN}, 32'd1);
    drain();
    check("ovr_sticky", {31'd0, OVERRUN}, 32'd1);
    check("ovr_hold_end", {31'd0, HOLD_FULL}, 32'd0);
    RST = 1'b0;
    #1;
    check("ovr_rst_clr", {31'd0, OVERRUN}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // reset during WAIT_LO
    base = nbytes;
    exp_q.push_back(8'hFE);
    pulse(16'hCAFE, 1);
    for (int k = 0; k < 50 && !TX_BUSY; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, TX_D_VLD}, 32'd0);
    check("mid_rst_hold", {31'd0, HOLD_FULL}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    drain();
    repeat (20) @(negedge CLK);
    check("mid_rst_no_hi", nbytes, base + 1);

    // reset while valid is high drops it without waiting for a clock edge
    exp_q.push_back(8'h78);
    pulse(16'h5678, 1);
    #2;
    RST = 1'b0;
    #1;
    check("async_vld_drop", {31'd0, TX_D_VLD}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    drain();
    check("final_vld", {31'd0, TX_D_VLD}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_tx_framer.md
Name: alu_result_tx_framer

Overview:
- Sits directly downstream of the 16-bit-result ALU stage, between it and the UART transmitter, inside the system-controller datapath.
- Captures each registered ALU result qualified by OUT_VALID and splits it into D_WIDTH-bit bytes, low byte first.
- Hands each byte to the UART TX through a level valid/busy handshake.
- Buffers one pending result while a transmission is in progress; flags lost results.

Parameters:
D_WIDTH, 8, byte width; the ALU result width is 2*D_WIDTH.

Ports:
CLK  input  1  system clock, rising-edge.
RST  input  1  asynchronous, active-low reset.
ALU_OUT  input  2*D_WIDTH  ALU result; sampled only when OUT_VALID=1.
OUT_VALID  input  1  one-cycle qualifier for ALU_OUT.
TX_BUSY  input  1  UART TX busy, already synchronized to CLK.
TX_P_DATA  output  D_WIDTH  byte presented to the UART TX.
TX_D_VLD  output  1  byte-valid request to the UART TX.
HOLD_FULL  output  1  pending-result buffer occupied; upstream must not issue another result.
OVERRUN  output  1  sticky; a result was dropped.

Behaviour:
- Reset is asynchronous, active-low, on RST, clock CLK.
- Reset values: TX_P_DATA=0, TX_D_VLD=0, HOLD_FULL=0, OVERRUN=0, state=IDLE, active and hold registers=0.
- Every output is registered.
- Storage:
  - ACT register: 2*D_WIDTH bits, the result being sent.
  - HOLD register: 2*D_WIDTH bits, plus hold_vld.
  - HOLD_FULL = hold_vld.
- State machine: IDLE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- IDLE:
  - On OUT_VALID=1: load ACT<=ALU_OUT and go to SEND_LO.
  - TX_D_VLD and TX_P_DATA=ALU_OUT[D_WIDTH-1:0] are registered on the same edge.
  - Latency: OUT_VALID sampled at edge k gives TX_D_VLD=1 after edge k.
- SEND_LO:
  - TX_D_VLD=1 and TX_P_DATA=ACT low byte, held stable.
  - On TX_BUSY=1: TX_D_VLD<=0, go to WAIT_LO.
  - No timeout.
- WAIT_LO: on TX_BUSY=0, go to SEND_HI with TX_D_VLD<=1 and TX_P_DATA<=ACT[2*D_WIDTH-1:D_WIDTH].
- SEND_HI: same as SEND_LO, with exit to WAIT_HI.
- WAIT_HI, on TX_BUSY=0:
  - If hold_vld: ACT<=HOLD, hold_vld<=0, go to SEND_LO presenting the new low byte.
  - Otherwise go to IDLE with TX_D_VLD=0.
- OUT_VALID in any non-IDLE state:
  - hold_vld=0: HOLD<=ALU_OUT, hold_vld<=1.
  - hold_vld=1: result discarded, OVERRUN<=1.
- Simultaneous events at the WAIT_HI exit edge when hold_vld=1 and OUT_VALID=1:
  - HOLD moves to ACT.
  - The new ALU_OUT is written to HOLD; hold_vld stays 1.
  - No overrun.
- A result is always sent in full as two bytes; a zero result is still sent.
- TX_BUSY already high on entry to SEND_*: the handshake completes on the next edge; stale busy is not checked.
- OVERRUN clears only on reset.
- Reset mid-transfer: all state is discarded, TX_D_VLD drops asynchronously, and no partial frame is resumed.
- TX_P_DATA keeps its last value in IDLE and WAIT_* states.

Test Plan:
- Reset: RST=0 with OUT_VALID toggling -> all outputs 0; release RST -> state IDLE, outputs unchanged until OUT_VALID.
- Single result ALU_OUT=16'hA55A, OUT_VALID pulse; TX model asserts busy 2 cycles after TX_D_VLD and holds it 10 cycles:
  - TX_P_DATA=8'h5A, then 8'hA5.
  - TX_D_VLD low during each busy window.
  - IDLE reached; HOLD_FULL never set.
- Back-to-back: 16'h0102 then 16'h0304 three cycles later:
  - HOLD_FULL=1 after the second pulse.
  - Bytes sent 02,01,04,03 with no idle gap between frames.
  - HOLD_FULL clears at the WAIT_HI exit of the first frame.
- Overrun: three results 16'h1111, 16'h2222, 16'h3333 while the first is in SEND_LO:
  - Bytes sent 11,11,22,22.
  - 16'h3333 is dropped and OVERRUN=1, held until reset.
- Simultaneous: OUT_VALID=16'h00FF on the exact WAIT_HI exit edge with HOLD=16'hBEEF:
  - Bytes sent EF,BE,FF,00.
  - OVERRUN stays 0.
- Reset mid-frame: RST asserted during WAIT_LO of 16'hCAFE -> TX_D_VLD=0 immediately; after release, no high byte CA is sent.
